// File: rtl/mips_cpu_harvard.sv
// Single-cycle MIPS I subset core with separate instruction and data ports.
// A pc/npc register pair implements the architectural branch delay slot.
module mips_cpu_harvard (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic        active_q, active_d;
    logic [31:0] regs_q [0:31];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] jtarget;
    logic [31:0] rs_val, rt_val, imm_sext, imm_zext;
    logic [31:0] pc_plus4, pc_plus8, br_target;

    logic        wr_en_raw, taken, mem_rd, mem_wr, commit;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data, target;
    logic        rf_we;

    assign opcode  = instr_readdata[31:26];
    assign rs      = instr_readdata[25:21];
    assign rt      = instr_readdata[20:16];
    assign rd      = instr_readdata[15:11];
    assign shamt   = instr_readdata[10:6];
    assign funct   = instr_readdata[5:0];
    assign imm     = instr_readdata[15:0];
    assign jtarget = instr_readdata[25:0];

    assign rs_val   = (rs == 5'd0) ? 32'h0 : regs_q[rs];
    assign rt_val   = (rt == 5'd0) ? 32'h0 : regs_q[rt];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0, imm};

    // pc_q is the address of the executing instruction, so link and branch
    // offsets are relative to it even when it sits in a delay slot.
    assign pc_plus4  = pc_q + 32'd4;
    assign pc_plus8  = pc_q + 32'd8;
    assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};

    always_comb begin
        wr_en_raw = 1'b0;
        wr_addr   = rt;
        wr_data   = 32'h0;
        taken     = 1'b0;
        target    = br_target;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                wr_addr   = rd;
                wr_en_raw = 1'b1;
                case (funct)
                    F_SLL:  wr_data = rt_val << shamt;
                    F_SRL:  wr_data = rt_val >> shamt;
                    F_SRA:  wr_data = $signed(rt_val) >>> shamt;
                    F_SLLV: wr_data = rt_val << rs_val[4:0];
                    F_SRLV: wr_data = rt_val >> rs_val[4:0];
                    F_SRAV: wr_data = $signed(rt_val) >>> rs_val[4:0];
                    F_ADDU: wr_data = rs_val + rt_val;
                    F_SUBU: wr_data = rs_val - rt_val;
                    F_AND:  wr_data = rs_val & rt_val;
                    F_OR:   wr_data = rs_val | rt_val;
                    F_XOR:  wr_data = rs_val ^ rt_val;
                    F_SLT:  wr_data = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    F_SLTU: wr_data = {31'h0, rs_val < rt_val};
                    F_JR: begin
                        wr_en_raw = 1'b0;
                        taken     = 1'b1;
                        target    = rs_val;
                    end
                    F_JALR: begin
                        taken   = 1'b1;
                        target  = rs_val;
                        wr_data = pc_plus8;
                    end
                    default: wr_en_raw = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                if (rt == 5'd0) taken = rs_val[31];
                if (rt == 5'd1) taken = !rs_val[31];
            end
            OP_J, OP_JAL: begin
                taken     = 1'b1;
                target    = {pc_plus4[31:28], jtarget, 2'b00};
                wr_en_raw = (opcode == OP_JAL);
                wr_addr   = 5'd31;
                wr_data   = pc_plus8;
            end
            OP_BEQ:  taken = (rs_val == rt_val);
            OP_BNE:  taken = (rs_val != rt_val);
            OP_BLEZ: taken = rs_val[31] || (rs_val == 32'h0);
            OP_BGTZ: taken = !rs_val[31] && (rs_val != 32'h0);
            OP_ADDIU: begin wr_en_raw = 1'b1; wr_data = rs_val + imm_sext; end
            OP_SLTI:  begin wr_en_raw = 1'b1; wr_data = {31'h0, $signed(rs_val) < $signed(imm_sext)}; end
            OP_SLTIU: begin wr_en_raw = 1'b1; wr_data = {31'h0, rs_val < imm_sext}; end
            OP_ANDI:  begin wr_en_raw = 1'b1; wr_data = rs_val & imm_zext; end
            OP_ORI:   begin wr_en_raw = 1'b1; wr_data = rs_val | imm_zext; end
            OP_XORI:  begin wr_en_raw = 1'b1; wr_data = rs_val ^ imm_zext; end
            OP_LUI:   begin wr_en_raw = 1'b1; wr_data = {imm, 16'h0}; end
            OP_LW: begin
                mem_rd    = 1'b1;
                wr_en_raw = 1'b1;
                wr_data   = data_readdata;
            end
            OP_SW:   mem_wr = 1'b1;
            default: ;
        endcase
    end

    // An npc of zero means the instruction now retiring is the delay slot of
    // the return-to-zero jump: it still completes, then the core halts.
    always_comb begin
        commit   = active_q && clk_enable;
        pc_d     = pc_q;
        npc_d    = npc_q;
        active_d = active_q;
        if (commit) begin
            pc_d  = npc_q;
            npc_d = taken ? target : (npc_q + 32'd4);
            if (npc_q == 32'h0) active_d = 1'b0;
        end
        rf_we = commit && wr_en_raw && (wr_addr != 5'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            npc_q    <= RESET_PC + 32'd4;
            active_q <= 1'b1;
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
        end else begin
            pc_q     <= pc_d;
            npc_q    <= npc_d;
            active_q <= active_d;
            if (rf_we) regs_q[wr_addr] <= wr_data;
        end
    end

    assign active         = active_q;
    assign register_v0    = regs_q[2];
    assign instr_address  = pc_q;
    assign data_address   = rs_val + imm_sext;
    assign data_writedata = rt_val;
    assign data_read      = mem_rd && active_q && reset;
    assign data_write     = mem_wr && active_q && clk_enable && reset;

endmodule

// File: tb/tb_mips_cpu_harvard.sv
// Directed bench for mips_cpu_harvard with a small ROM/RAM model around it.
module tb_mips_cpu_harvard;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b0;
    logic        active;
    logic [31:0] register_v0, instr_address, instr_readdata;
    logic [31:0] data_address, data_writedata, data_readdata;
    logic        data_write, data_read;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];
    logic [31:0] rom_off;
    logic [31:0] exp_v0 [0:15];
    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP    = 32'h0;

    mips_cpu_harvard dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .clk_enable(clk_enable), .instr_address(instr_address),
        .instr_readdata(instr_readdata), .data_address(data_address),
        .data_write(data_write), .data_read(data_read),
        .data_writedata(data_writedata), .data_readdata(data_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    // Address 0 holds ADDIU $2,$2,1 so a halted core that kept executing would show it.
    always_comb begin
        rom_off = instr_address - RST_PC;
        if (instr_address == 32'h0)  instr_readdata = enc_i(6'h09, 5'd2, 5'd2, 16'd1);
        else if (rom_off < 32'd256)  instr_readdata = imem[rom_off[7:2]];
        else                         instr_readdata = NOP;
    end

    assign data_readdata = dmem[data_address[7:2]];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
        end else if (data_write) begin
            dmem[data_address[7:2]] <= data_writedata;
        end
    end

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = NOP;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0;
        clk_enable = 1'b1;
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_imem();
        imem[0] = enc_i(6'h2B, 5'd0, 5'd2, 16'd0);
        step();
        reset = 1'b0;
        clk_enable = 1'b1;
        #1;
        n_cmp++; if (active !== 1'b1) begin n_bad++; $display("FAIL reset_active: got %b want 1", active); end
        n_cmp++; if (instr_address !== RST_PC) begin n_bad++; $display("FAIL reset_pc: got %h want %h", instr_address, RST_PC); end
        n_cmp++; if (register_v0 !== 32'h0) begin n_bad++; $display("FAIL reset_v0: got %h want 0", register_v0); end
        n_cmp++; if (data_write !== 1'b0) begin n_bad++; $display("FAIL reset_dwrite: got %b want 0", data_write); end
        n_cmp++; if (data_read !== 1'b0) begin n_bad++; $display("FAIL reset_dread: got %b want 0", data_read); end
        step();
        n_cmp++; if (instr_address !== RST_PC) begin n_bad++; $display("FAIL reset_hold_pc: got %h want %h", instr_address, RST_PC); end
        reset = 1'b1;
        #1;
        n_cmp++; if (data_write !== 1'b1 || data_address !== 32'h0) begin
            n_bad++; $display("FAIL release_sw: got we=%b addr=%h want 1/0", data_write, data_address); end
        step();
        n_cmp++; if (instr_address !== RST_PC + 32'd4) begin n_bad++; $display("FAIL first_fetch: got %h want %h", instr_address, RST_PC + 32'd4); end
    endtask

    task automatic test_addiu_halt();
        clear_imem();
        imem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'd5);
        imem[1] = enc_i(6'h09, 5'd2, 5'd2, 16'hFFFF);
        imem[2] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[3] = NOP;
        do_reset();
        step();
        n_cmp++; if (register_v0 !== 32'd5) begin n_bad++; $display("FAIL addiu_v0_5: got %h want 5", register_v0); end
        step();
        n_cmp++; if (register_v0 !== 32'd4) begin n_bad++; $display("FAIL addiu_v0_4: got %h want 4", register_v0); end
        step();
        n_cmp++; if (active !== 1'b1 || instr_address !== RST_PC + 32'hC) begin
            n_bad++; $display("FAIL jr_slot: got act=%b pc=%h want 1/%h", active, instr_address, RST_PC + 32'hC); end
        step();
        n_cmp++; if (active !== 1'b0 || instr_address !== 32'h0) begin
            n_bad++; $display("FAIL halt: got act=%b pc=%h want 0/0", active, instr_address); end
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (active !== 1'b0 || instr_address !== 32'h0 || register_v0 !== 32'd4 || data_write !== 1'b0) begin
            n_bad++; $display("FAIL halted_hold: got act=%b pc=%h v0=%h we=%b want 0/0/4/0",
                              active, instr_address, register_v0, data_write); end
    endtask

    task automatic test_load_store();
        int we_cnt;
        logic [31:0] we_addr;
        we_cnt = 0;
        we_addr = 32'hFFFF_FFFF;
        clear_imem();
        imem[0] = enc_i(6'h0F, 5'd0, 5'd3, 16'h1234);
        imem[1] = enc_i(6'h0D, 5'd3, 5'd3, 16'h5678);
        imem[2] = enc_i(6'h2B, 5'd0, 5'd3, 16'd0);
        imem[3] = enc_i(6'h23, 5'd0, 5'd2, 16'd0);
        imem[4] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[5] = NOP;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (data_write === 1'b1) begin
                we_cnt++;
                we_addr = data_address;
            end
            step();
        end
        n_cmp++; if (we_cnt != 1) begin n_bad++; $display("FAIL sw_strobe_count: got %0d want 1", we_cnt); end
        n_cmp++; if (we_addr !== 32'h0) begin n_bad++; $display("FAIL sw_addr: got %h want 0", we_addr); end
        n_cmp++; if (dmem[0] !== 32'h1234_5678) begin n_bad++; $display("FAIL sw_data: got %h want 12345678", dmem[0]); end
        n_cmp++; if (register_v0 !== 32'h1234_5678 || active !== 1'b0) begin
            n_bad++; $display("FAIL lw_v0: got v0=%h act=%b want 12345678/0", register_v0, active); end
    endtask

    task automatic test_branch_delay();
        clear_imem();
        imem[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
        imem[1] = enc_i(6'h09, 5'd0, 5'd2, 16'd7);
        imem[2] = enc_i(6'h09, 5'd0, 5'd2, 16'd9);
        imem[3] = enc_i(6'h09, 5'd2, 5'd2, 16'd1);
        imem[4] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[5] = NOP;
        do_reset();
        step();
        step();
        n_cmp++; if (register_v0 !== 32'd7 || instr_address !== RST_PC + 32'hC) begin
            n_bad++; $display("FAIL beq_slot: got v0=%h pc=%h want 7/%h", register_v0, instr_address, RST_PC + 32'hC); end
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (register_v0 !== 32'd8 || active !== 1'b0) begin
            n_bad++; $display("FAIL beq_result: got v0=%h act=%b want 8/0", register_v0, active); end
    endtask

    task automatic test_alu();
        clear_imem();
        imem[0]  = enc_i(6'h09, 5'd0, 5'd2, 16'hFFF8);
        imem[1]  = enc_r(5'd0, 5'd2, 5'd2, 5'd1, 6'h03);
        imem[2]  = enc_r(5'd0, 5'd2, 5'd2, 5'd28, 6'h02);
        imem[3]  = enc_i(6'h09, 5'd0, 5'd5, 16'hFFFF);
        imem[4]  = enc_r(5'd2, 5'd5, 5'd2, 5'd0, 6'h2B);
        imem[5]  = enc_r(5'd0, 5'd5, 5'd2, 5'd0, 6'h2A);
        imem[6]  = enc_i(6'h0B, 5'd0, 5'd2, 16'hFFFF);
        imem[7]  = enc_i(6'h0E, 5'd5, 5'd2, 16'h8000);
        imem[8]  = enc_r(5'd0, 5'd5, 5'd2, 5'd0, 6'h23);
        imem[9]  = enc_r(5'd5, 5'd5, 5'd2, 5'd0, 6'h04);
        imem[10] = enc_r(5'd5, 5'd2, 5'd2, 5'd0, 6'h07);
        imem[11] = enc_i(6'h09, 5'd0, 5'd0, 16'd5);
        imem[12] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h25);
        imem[13] = enc_i(6'h05, 5'd2, 5'd0, 16'd1);
        imem[14] = enc_i(6'h09, 5'd2, 5'd2, 16'd1);
        imem[15] = enc_i(6'h09, 5'd2, 5'd2, 16'd2);
        imem[16] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[17] = NOP;
        exp_v0 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_000F, 32'h0000_000F,
                   32'h1, 32'h0, 32'h1, 32'hFFFF_7FFF, 32'h1, 32'h8000_0000,
                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1, 32'h3};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step();
            n_cmp++; if (register_v0 !== exp_v0[i]) begin
                n_bad++; $display("FAIL alu_step%0d: got %h want %h", i, register_v0, exp_v0[i]); end
        end
        step();
        step();
        n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL alu_halt: got %b want 0", active); end
    endtask

    task automatic test_jal_jr();
        clear_imem();
        imem[0]  = enc_j(6'h03, 26'h3F0_0008);
        imem[1]  = enc_i(6'h09, 5'd0, 5'd2, 16'd1);
        imem[2]  = enc_i(6'h09, 5'd2, 5'd2, 16'd10);
        imem[3]  = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[4]  = NOP;
        imem[8]  = enc_r(5'd31, 5'd0, 5'd2, 5'd0, 6'h25);
        imem[9]  = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[10] = enc_i(6'h09, 5'd0, 5'd2, 16'd1);
        do_reset();
        step();
        step();
        n_cmp++; if (instr_address !== RST_PC + 32'h20 || register_v0 !== 32'd1) begin
            n_bad++; $display("FAIL jal_target: got pc=%h v0=%h want %h/1", instr_address, register_v0, RST_PC + 32'h20); end
        step();
        n_cmp++; if (register_v0 !== RST_PC + 32'd8) begin
            n_bad++; $display("FAIL jal_link: got %h want %h", register_v0, RST_PC + 32'd8); end
        step();
        step();
        n_cmp++; if (instr_address !== RST_PC + 32'd8) begin
            n_bad++; $display("FAIL jr_return: got %h want %h", instr_address, RST_PC + 32'd8); end
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (register_v0 !== 32'd11 || active !== 1'b0) begin
            n_bad++; $display("FAIL jal_final: got v0=%h act=%b want 11/0", register_v0, active); end
    endtask

    task automatic test_clk_enable_reset();
        clear_imem();
        imem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'd1);
        imem[1] = enc_i(6'h09, 5'd2, 5'd2, 16'd1);
        imem[2] = enc_i(6'h2B, 5'd0, 5'd2, 16'd4);
        imem[3] = enc_i(6'h09, 5'd2, 5'd2, 16'd1);
        do_reset();
        step();
        step();
        clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (instr_address !== RST_PC + 32'd8 || register_v0 !== 32'd2 || data_write !== 1'b0) begin
                n_bad++; $display("FAIL freeze%0d: got pc=%h v0=%h we=%b want %h/2/0",
                                  i, instr_address, register_v0, data_write, RST_PC + 32'd8); end
        end
        n_cmp++; if (dmem[1] !== 32'h0) begin n_bad++; $display("FAIL freeze_mem: got %h want 0", dmem[1]); end
        clk_enable = 1'b1;
        #1;
        n_cmp++; if (data_write !== 1'b1) begin n_bad++; $display("FAIL unfreeze_we: got %b want 1", data_write); end
        step();
        n_cmp++; if (dmem[1] !== 32'd2 || instr_address !== RST_PC + 32'hC) begin
            n_bad++; $display("FAIL unfreeze_sw: got mem=%h pc=%h want 2/%h", dmem[1], instr_address, RST_PC + 32'hC); end
        step();
        n_cmp++; if (register_v0 !== 32'd3) begin n_bad++; $display("FAIL resume_v0: got %h want 3", register_v0); end
        reset = 1'b0;
        #1;
        n_cmp++; if (instr_address !== RST_PC || register_v0 !== 32'h0 || active !== 1'b1) begin
            n_bad++; $display("FAIL async_reset: got pc=%h v0=%h act=%b want %h/0/1",
                              instr_address, register_v0, active, RST_PC); end
        step();
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addiu_halt();
        test_load_store();
        test_branch_delay();
        test_alu();
        test_jal_jr();
        test_clk_enable_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
